udp_tx_arbiter: RTL and testbench
=================================

# udp_tx_arbiter

Packet-atomic round-robin arbiter that shares the single 1 GbE UDP TX data/status FIFO pair between up to N_SRC packet sources (acquisition stream decoders, ack/command-reply decoders). Each source requests access, receives an exclusive grant for one whole packet (data bytes followed by one status word) and releases it by writing its status. The block sits between the decoders and the Ethernet TX FIFOs. It registers the muxed write path and includes a watchdog that revokes a stalled grant.

## Interface
- N_SRC, 4, number of requesting sources (2..8)
- AVL_SIZE, 8, data byte width
- STATUS_WIDTH, 96, status word width (2×8 length + 32 IP + 48 MAC)
- TIMEOUT_CYCLES, 4096, maximum grant duration in cycles before revocation
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- src_req  in  N_SRC  per-source request, level
- src_grant  out  N_SRC  one-hot grant, registered
- src_data  in  N_SRC*AVL_SIZE  source i occupies [i*AVL_SIZE +: AVL_SIZE]
- src_data_write  in  N_SRC  per-source data strobe
- src_status  in  N_SRC*STATUS_WIDTH  source i occupies [i*STATUS_WIDTH +: STATUS_WIDTH]
- src_status_write  in  N_SRC  per-source status strobe; marks end of packet
- src_data_full  out  N_SRC  tx_fifo_data_full for the granted source, 1 for all others
- src_status_full  out  N_SRC  tx_fifo_status_full for the granted source, 1 for all others
- tx_fifo_data  out  AVL_SIZE  registered muxed data
- tx_fifo_data_write  out  1  registered muxed strobe
- tx_fifo_status  out  STATUS_WIDTH  registered muxed status
- tx_fifo_status_write  out  1  registered muxed strobe
- tx_fifo_data_full  in  1  downstream data FIFO full
- tx_fifo_status_full  in  1  downstream status FIFO full
- timeout_pulse  out  1  one-cycle pulse on grant revocation
- timeout_src  out  $clog2(N_SRC)  index of the revoked source; holds until the next timeout
- packet_count  out  16  count of forwarded status writes; wraps 0xFFFF→0

## Operation
- States: IDLE, BUSY, GAP.
- Reset values: all outputs 0, except src_data_full and src_status_full, which reset to all ones. rr_ptr=0, watchdog=0, state IDLE.
- IDLE:
  - If any src_req is high and tx_fifo_status_full=0, select the first requester scanning from rr_ptr upward, modulo N_SRC.
  - Set its src_grant bit, clear the watchdog, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Only the granted source's data, status and strobes are forwarded. Strobes from non-granted sources are ignored and dropped.
  - Writes are forwarded unconditionally. The source must respect src_data_full and src_status_full.
  - The watchdog increments every BUSY cycle.
  - On a granted src_status_write: forward it, clear the grant, increment packet_count, set rr_ptr to (granted+1) mod N_SRC, go to GAP.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no granted status write: clear the grant, pulse timeout_pulse, load timeout_src, advance rr_ptr as above, go to GAP. No status is synthesized.
  - A src_req deassertion while granted has no effect. The grant is held until status write or timeout.
- GAP: one cycle with no forwarded writes; then go to IDLE. This gives the downstream empty/full flags time to settle after a status write.
- Simultaneous granted status write and watchdog expiry: the status write wins; no timeout pulse.
- Simultaneous data and status strobe from the granted source: both are forwarded in the same cycle.
- Reset in mid-packet: grant is dropped and in-flight registered writes are cleared on the next edge. A partial packet may remain in the downstream data FIFO.

## Timing
- Request-to-grant: src_req high at IDLE edge t gives src_grant high at t+1.
- Forward latency: a source strobe at cycle k appears on tx_fifo_* at k+1, with data and status aligned to their strobes.
- Release: granted src_status_write at t_s gives tx_fifo_status_write and src_grant=0 at t_s+1, GAP at t_s+1, IDLE at t_s+2, earliest next grant at t_s+3.
- src_data_full and src_status_full are combinational from the grant register and the downstream full inputs.
- Timeout: if the grant rises at g, revocation occurs at g+TIMEOUT_CYCLES and timeout_pulse is high for that single cycle.

## Test plan
- Single source 0 requests and sends a header plus 32 data bytes plus status → exactly 33 tx_fifo_data_write pulses and 1 tx_fifo_status_write, each 1 cycle after the source strobe; packet_count=1; grant is high from t+1 to t_s.
- All 4 sources request continuously, each sending 4-byte packets → grant order 0,1,2,3,0,…; 3-cycle gap between one status write and the next grant; no interleaved bytes.
- Source 2 writes data while source 1 holds the grant → source 2's bytes are not forwarded, and src_data_full[2]=1 throughout.
- Granted source never writes status, with TIMEOUT_CYCLES=16 → grant drops 16 cycles after it rose; timeout_pulse high for 1 cycle; timeout_src=granted index; next requester is served.
- tx_fifo_status_full=1 in IDLE with requests pending → no grant; grant is issued 1 cycle after full deasserts. Separately, status write on the same cycle as watchdog expiry → status forwarded and no timeout_pulse.
- Reset asserted mid-packet → all strobes and grants are 0 on the next edge; after release, rr_ptr=0 and source 0 is granted first.

Source files
------------

// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: source-side and TX FIFO-side signals of the UDP TX arbiter
interface udp_tx_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int AVL_SIZE = 8,
  parameter int STATUS_WIDTH = 96
);
  logic [N_SRC-1:0] src_req;
  logic [N_SRC-1:0] src_grant;
  logic [N_SRC*AVL_SIZE-1:0] src_data;
  logic [N_SRC-1:0] src_data_write;
  logic [N_SRC*STATUS_WIDTH-1:0] src_status;
  logic [N_SRC-1:0] src_status_write;
  logic [N_SRC-1:0] src_data_full;
  logic [N_SRC-1:0] src_status_full;
  logic [AVL_SIZE-1:0] tx_fifo_data;
  logic tx_fifo_data_write;
  logic [STATUS_WIDTH-1:0] tx_fifo_status;
  logic tx_fifo_status_write;
  logic tx_fifo_data_full;
  logic tx_fifo_status_full;
  logic timeout_pulse;
  logic [$clog2(N_SRC)-1:0] timeout_src;
  logic [15:0] packet_count;
  modport master (
    output src_req, src_data, src_data_write, src_status, src_status_write,
    output tx_fifo_data_full, tx_fifo_status_full,
    input src_grant, src_data_full, src_status_full,
    input tx_fifo_data, tx_fifo_data_write, tx_fifo_status, tx_fifo_status_write,
    input timeout_pulse, timeout_src, packet_count
  );
  modport slave (
    input src_req, src_data, src_data_write, src_status, src_status_write,
    input tx_fifo_data_full, tx_fifo_status_full,
    output src_grant, src_data_full, src_status_full,
    output tx_fifo_data, tx_fifo_data_write, tx_fifo_status, tx_fifo_status_write,
    output timeout_pulse, timeout_src, packet_count
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet-atomic round-robin sharing of the UDP TX data/status FIFO pair
module udp_tx_arbiter #(
  parameter int N_SRC = 4,
  parameter int AVL_SIZE = 8,
  parameter int STATUS_WIDTH = 96,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic reset,
  udp_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_SRC);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state, state_n;
  logic [N_SRC-1:0] grant, grant_n;
  logic [IW-1:0] gidx, gidx_n, rr_ptr, rr_n, pick;
  logic [WW-1:0] wd, wd_n;
  logic fwd_d, fwd_s, to_n;
  assign bus.src_grant = grant;
  assign bus.src_data_full = ~grant | {N_SRC{bus.tx_fifo_data_full}};
  assign bus.src_status_full = ~grant | {N_SRC{bus.tx_fifo_status_full}};
  // scan downward so the requester closest to rr_ptr is written last and wins
  always_comb begin
    pick = rr_ptr;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (bus.src_req[(int'(rr_ptr) + k) % N_SRC]) pick = IW'((int'(rr_ptr) + k) % N_SRC);
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    gidx_n = gidx;
    wd_n = wd;
    rr_n = rr_ptr;
    fwd_d = state == BUSY && bus.src_data_write[gidx];
    fwd_s = state == BUSY && bus.src_status_write[gidx];
    to_n = state == BUSY && !fwd_s && wd == WW'(TIMEOUT_CYCLES - 1);
    case (state)
      IDLE: if (|bus.src_req && !bus.tx_fifo_status_full) begin
        state_n = BUSY;
        grant_n = N_SRC'(1) << pick;
        gidx_n = pick;
        wd_n = '0;
      end
      BUSY: begin
        wd_n = wd + 1'b1;
        if (fwd_s || to_n) begin
          state_n = GAP;
          grant_n = '0;
          rr_n = gidx == IW'(N_SRC - 1) ? '0 : gidx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      gidx <= '0;
      rr_ptr <= '0;
      wd <= '0;
      bus.tx_fifo_data <= '0;
      bus.tx_fifo_data_write <= 1'b0;
      bus.tx_fifo_status <= '0;
      bus.tx_fifo_status_write <= 1'b0;
      bus.timeout_pulse <= 1'b0;
      bus.timeout_src <= '0;
      bus.packet_count <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      gidx <= gidx_n;
      rr_ptr <= rr_n;
      wd <= wd_n;
      bus.tx_fifo_data <= fwd_d ? bus.src_data[gidx*AVL_SIZE +: AVL_SIZE] : bus.tx_fifo_data;
      bus.tx_fifo_data_write <= fwd_d;
      bus.tx_fifo_status <= fwd_s ? bus.src_status[gidx*STATUS_WIDTH +: STATUS_WIDTH] : bus.tx_fifo_status;
      bus.tx_fifo_status_write <= fwd_s;
      bus.timeout_pulse <= to_n;
      bus.timeout_src <= to_n ? gidx : bus.timeout_src;
      bus.packet_count <= bus.packet_count + 16'(fwd_s);
    end
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: scoreboard bench for the UDP TX arbiter
module tb_udp_tx_arbiter;
  localparam int N = 4;
  localparam int AW = 8;
  localparam int SW = 96;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] dq[$];
  logic [SW-1:0] sq[$];
  int n_chk = 0;
  int n_pass = 0;
  int dw_cnt = 0;
  int sw_cnt = 0;
  udp_tx_arbiter_if #(.N_SRC(N), .AVL_SIZE(AW), .STATUS_WIDTH(SW)) bus();
  udp_tx_arbiter #(.N_SRC(N), .AVL_SIZE(AW), .STATUS_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(posedge clk) begin
    #1;
    if (bus.tx_fifo_data_write) begin
      dw_cnt++;
      if (dq.size() == 0) chk("stray_data", bus.tx_fifo_data_write, 0);
      else chk("data", bus.tx_fifo_data, dq.pop_front());
    end
    if (bus.tx_fifo_status_write) begin
      sw_cnt++;
      if (sq.size() == 0) chk("stray_status", bus.tx_fifo_status_write, 0);
      else chk("status", bus.tx_fifo_status, sq.pop_front());
    end
  end
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic send(input int s, input int n, input int stray);
    logic [AW-1:0] b;
    logic [SW-1:0] st;
    for (int i = 0; i < n; i++) begin
      b = AW'($urandom);
      bus.src_data[s*AW +: AW] = b;
      bus.src_data_write[s] = 1'b1;
      dq.push_back(b);
      if (stray >= 0) begin
        bus.src_data[stray*AW +: AW] = 8'hEE;
        bus.src_data_write[stray] = 1'b1;
      end
      tick;
      chk("fwd_data", bus.tx_fifo_data_write, 1);
      chk("grant_hold", bus.src_grant, N'(1) << s);
      if (stray >= 0) chk("stray_full", bus.src_data_full[stray], 1);
    end
    bus.src_data_write = '0;
    st = {$urandom, $urandom, $urandom};
    bus.src_status[s*SW +: SW] = st;
    bus.src_status_write[s] = 1'b1;
    sq.push_back(st);
    tick;
    bus.src_status_write = '0;
    chk("fwd_status", bus.tx_fifo_status_write, 1);
    chk("release", bus.src_grant, 0);
  endtask
  task automatic gap_grant(input int s);
    tick;
    chk("gap", bus.src_grant, 0);
    tick;
    chk("grant", bus.src_grant, N'(1) << s);
  endtask
  initial begin
    logic [AW-1:0] b;
    logic [SW-1:0] st;
    bus.src_req = '0;
    bus.src_data = '0;
    bus.src_data_write = '0;
    bus.src_status = '0;
    bus.src_status_write = '0;
    bus.tx_fifo_data_full = 1'b0;
    bus.tx_fifo_status_full = 1'b0;
    repeat (3) tick;
    chk("rst_grant", bus.src_grant, 0);
    chk("rst_dfull", bus.src_data_full, 4'hF);
    chk("rst_sfull", bus.src_status_full, 4'hF);
    chk("rst_dw", bus.tx_fifo_data_write, 0);
    chk("rst_sw", bus.tx_fifo_status_write, 0);
    chk("rst_pc", bus.packet_count, 0);
    chk("rst_to", bus.timeout_pulse, 0);
    reset = 1'b0;
    bus.src_req = 4'b0001;
    tick;
    chk("first_grant", bus.src_grant, 4'b0001);
    dw_cnt = 0;
    sw_cnt = 0;
    send(0, 33, -1);
    bus.src_req = '0;
    chk("t1_dw_cnt", dw_cnt, 33);
    chk("t1_sw_cnt", sw_cnt, 1);
    chk("t1_pc", bus.packet_count, 1);
    bus.src_req = 4'b0011;
    gap_grant(1);
    b = AW'($urandom);
    bus.src_data[1*AW +: AW] = b;
    bus.src_data_write[1] = 1'b1;
    dq.push_back(b);
    tick;
    bus.src_data[1*AW +: AW] = 8'h5A;
    bus.src_status_write[1] = 1'b1;
    reset = 1'b1;
    tick;
    chk("rst_mid_dw", bus.tx_fifo_data_write, 0);
    chk("rst_mid_sw", bus.tx_fifo_status_write, 0);
    chk("rst_mid_grant", bus.src_grant, 0);
    bus.src_data_write = '0;
    bus.src_status_write = '0;
    bus.src_req = 4'b1111;
    reset = 1'b0;
    tick;
    chk("rst_rr_grant", bus.src_grant, 4'b0001);
    chk("rst_mid_pc", bus.packet_count, 0);
    for (int p = 0; p < 5; p++) begin
      if (p > 0) gap_grant(p % N);
      send(p % N, 4, (p % N) == 1 ? 2 : -1);
    end
    bus.src_req = '0;
    chk("rr_pc", bus.packet_count, 5);
    bus.tx_fifo_status_full = 1'b1;
    bus.src_req = 4'b0100;
    repeat (4) begin
      tick;
      chk("sfull_nogrant", bus.src_grant, 0);
    end
    bus.tx_fifo_status_full = 1'b0;
    tick;
    chk("sfull_grant", bus.src_grant, 4'b0100);
    chk("sfull_flags", bus.src_status_full, 4'b1011);
    bus.tx_fifo_data_full = 1'b1;
    #1 chk("dfull_on", bus.src_data_full, 4'hF);
    bus.tx_fifo_data_full = 1'b0;
    #1 chk("dfull_off", bus.src_data_full, 4'b1011);
    send(2, 2, -1);
    bus.src_req = 4'b1001;
    gap_grant(3);
    repeat (TO - 1) tick;
    chk("to_hold", bus.src_grant, 4'b1000);
    chk("to_early", bus.timeout_pulse, 0);
    tick;
    chk("to_grant", bus.src_grant, 0);
    chk("to_pulse", bus.timeout_pulse, 1);
    chk("to_src", bus.timeout_src, 3);
    tick;
    chk("to_pulse_end", bus.timeout_pulse, 0);
    chk("to_src_hold", bus.timeout_src, 3);
    tick;
    chk("to_next", bus.src_grant, 4'b0001);
    repeat (TO - 1) tick;
    b = AW'($urandom);
    st = {$urandom, $urandom, $urandom};
    bus.src_data[0 +: AW] = b;
    bus.src_data_write[0] = 1'b1;
    bus.src_status[0 +: SW] = st;
    bus.src_status_write[0] = 1'b1;
    dq.push_back(b);
    sq.push_back(st);
    tick;
    bus.src_data_write = '0;
    bus.src_status_write = '0;
    bus.src_req = '0;
    chk("race_pulse", bus.timeout_pulse, 0);
    chk("race_sw", bus.tx_fifo_status_write, 1);
    chk("race_dw", bus.tx_fifo_data_write, 1);
    chk("race_grant", bus.src_grant, 0);
    chk("race_pc", bus.packet_count, 7);
    chk("race_tsrc", bus.timeout_src, 3);
    repeat (3) tick;
    chk("dq_empty", dq.size(), 0);
    chk("sq_empty", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
